// File: rtl/c1541_gcr_pkg.sv
// Shared types and constants for the 1541 GCR read path: state encoding, block marks and the
// 4-to-5 GCR code table with its inverse.
package c1541_gcr_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StSync,
    StMark,
    StHeader,
    StData
  } dec_state_e;

  localparam logic [7:0]  MarkHeader = 8'h08;
  localparam logic [7:0]  MarkData   = 8'h07;
  localparam int unsigned SectorsMax = 20;

  // Indexed by nibble value; entry 15 is listed first.
  localparam logic [15:0][4:0] GcrEncode = {
    5'h15, 5'h1e, 5'h1d, 5'h0d, 5'h1b, 5'h1a, 5'h19, 5'h09,
    5'h17, 5'h16, 5'h0f, 5'h0e, 5'h13, 5'h12, 5'h0b, 5'h0a
  };

  // Returns {valid, nibble}; any code not in the table is illegal.
  function automatic logic [4:0] gcr_decode(input logic [4:0] code);
    logic [4:0] res;
    res = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (GcrEncode[i] == code) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/c1541_gcr_deframer.sv
// Bit-level front end: ones counter / SYNC detect and 10-bit GCR group framing with a one-ce
// group-ready pulse after the 10th bit.
module c1541_gcr_deframer
  import c1541_gcr_pkg::*;
#(
  parameter int unsigned SyncOnes = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       bit_valid_i,
  input  logic       bit_in_i,
  output logic       sync_n_o,
  output logic       sync_hit_o,
  output logic       sync_exit_o,
  output logic       grp_rdy_o,
  output logic [9:0] grp_o
);

  localparam int unsigned      OnesW   = $clog2(SyncOnes + 1);
  localparam logic [OnesW-1:0] OnesMax = OnesW'(SyncOnes);
  localparam logic [OnesW-1:0] OnesPre = OnesW'(SyncOnes - 1);

  logic [OnesW-1:0] ones_q, ones_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [9:0]       grp_q, grp_d;
  logic             rdy_q, rdy_d;
  logic             bit_ev, in_sync, sync_hit, sync_exit;

  assign bit_ev    = ce_i & bit_valid_i;
  assign in_sync   = (ones_q == OnesMax);
  // Fires on the bit that reaches SYNC and on every further 1 while saturated.
  assign sync_hit  = bit_ev & bit_in_i & (ones_q >= OnesPre);
  assign sync_exit = bit_ev & ~bit_in_i & in_sync;

  always_comb begin
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    grp_d   = grp_q;
    rdy_d   = 1'b0;
    if (bit_ev) begin
      if (bit_in_i) begin
        ones_d = in_sync ? ones_q : ones_q + 1'b1;
      end else begin
        ones_d = '0;
      end
      if (sync_hit) begin
        // A group completing on the SYNC bit is dropped.
        cnt_d = 4'd0;
      end else if (sync_exit) begin
        // The terminating 0 is the first bit of the first group.
        cnt_d   = 4'd1;
        shift_d = 9'b0;
      end else begin
        shift_d = {shift_q[7:0], bit_in_i};
        if (cnt_q == 4'd9) begin
          cnt_d = 4'd0;
          grp_d = {shift_q, bit_in_i};
          rdy_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ones_q  <= '0;
      cnt_q   <= 4'd0;
      shift_q <= 9'b0;
      grp_q   <= 10'b0;
      rdy_q   <= 1'b0;
    end else if (ce_i) begin
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      grp_q   <= grp_d;
      rdy_q   <= rdy_d;
    end
  end

  assign sync_n_o    = ~in_sync;
  assign sync_hit_o  = sync_hit;
  assign sync_exit_o = sync_exit;
  assign grp_rdy_o   = rdy_q;
  assign grp_o       = grp_q;

endmodule

// File: rtl/c1541_gcr_decoder.sv
// 1541 GCR read decoder: parses header/data blocks and writes sector bytes to a D64-style buffer.
// Optional header track check: define C1541_GCR_DEC_TRACK_CHECK_EN.
module c1541_gcr_decoder
  import c1541_gcr_pkg::*;
#(
  parameter int unsigned SyncOnes  = 10,
  parameter int unsigned AddrWidth = 13
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ce_i,
  input  logic                 bit_valid_i,
  input  logic                 bit_in_i,
  input  logic [5:0]           track_i,
  output logic                 sync_n_o,
  output logic                 hdr_valid_o,
  output logic [7:0]           hdr_track_o,
  output logic [7:0]           hdr_sector_o,
  output logic [15:0]          hdr_id_o,
  output logic                 hdr_cks_ok_o,
  output logic                 buf_we_o,
  output logic [AddrWidth-1:0] buf_addr_o,
  output logic [7:0]           buf_data_o,
  output logic                 sector_done_o,
  output logic                 data_cks_ok_o,
  output logic                 gcr_err_o
);

  logic       sync_hit, sync_exit, grp_rdy;
  logic [9:0] grp;

  c1541_gcr_deframer #(
    .SyncOnes(SyncOnes)
  ) u_deframer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ce_i       (ce_i),
    .bit_valid_i(bit_valid_i),
    .bit_in_i   (bit_in_i),
    .sync_n_o   (sync_n_o),
    .sync_hit_o (sync_hit),
    .sync_exit_o(sync_exit),
    .grp_rdy_o  (grp_rdy),
    .grp_o      (grp)
  );

  logic [4:0] dec_hi, dec_lo;
  logic [7:0] dec_byte;
  logic       code_ok;

  assign dec_hi   = gcr_decode(grp[9:5]);
  assign dec_lo   = gcr_decode(grp[4:0]);
  assign code_ok  = dec_hi[4] & dec_lo[4];
  assign dec_byte = {dec_hi[3:0], dec_lo[3:0]};

  dec_state_e          state_q;
  logic                hdr_seen_q;
  logic [8:0]          cnt_q;
  logic [7:0]          xor_q, sec_q, trk_q, id2_q;
  logic                hdr_valid_q, hdr_cks_ok_q, buf_we_q, sector_done_q, data_cks_ok_q;
  logic                gcr_err_q;
  logic [7:0]          hdr_track_q, hdr_sector_q, buf_data_q;
  logic [15:0]         hdr_id_q;
  logic [AddrWidth-1:0] buf_addr_q;
  logic                hdr_ok, sec_ok, trk_match;

  // At the id1 byte the running XOR including cks must cancel to zero.
  assign hdr_ok = ((xor_q ^ dec_byte) == 8'h00);
  assign sec_ok = (sec_q <= 8'(SectorsMax));

`ifdef C1541_GCR_DEC_TRACK_CHECK_EN
  assign trk_match = (trk_q == {2'b00, track_i});
`else
  logic unused_track;
  assign trk_match    = 1'b1;
  assign unused_track = ^track_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StHunt;
      hdr_seen_q    <= 1'b0;
      cnt_q         <= 9'd0;
      xor_q         <= 8'h00;
      sec_q         <= 8'h00;
      trk_q         <= 8'h00;
      id2_q         <= 8'h00;
      hdr_valid_q   <= 1'b0;
      hdr_track_q   <= 8'h00;
      hdr_sector_q  <= 8'h00;
      hdr_id_q      <= 16'h0000;
      hdr_cks_ok_q  <= 1'b0;
      buf_we_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= 8'h00;
      sector_done_q <= 1'b0;
      data_cks_ok_q <= 1'b0;
      gcr_err_q     <= 1'b0;
    end else if (ce_i) begin
      hdr_valid_q   <= 1'b0;
      buf_we_q      <= 1'b0;
      sector_done_q <= 1'b0;
      gcr_err_q     <= 1'b0;
      if (sync_hit) begin
        state_q <= StSync;
      end else begin
        unique case (state_q)
          StHunt: state_q <= StHunt;
          StSync: begin
            if (sync_exit) state_q <= StMark;
          end
          StMark: begin
            if (grp_rdy) begin
              cnt_q <= 9'd0;
              xor_q <= 8'h00;
              if (!code_ok) begin
                gcr_err_q <= 1'b1;
                state_q   <= StHunt;
              end else if (dec_byte == MarkHeader) begin
                state_q <= StHeader;
              end else if (dec_byte == MarkData) begin
                state_q <= StData;
              end else begin
                state_q <= StHunt;
              end
            end
          end
          StHeader: begin
            if (grp_rdy) begin
              if (!code_ok) begin
                gcr_err_q <= 1'b1;
                state_q   <= StHunt;
              end else begin
                xor_q <= xor_q ^ dec_byte;
                cnt_q <= cnt_q + 9'd1;
                case (cnt_q[2:0])
                  3'd1: sec_q <= dec_byte;
                  3'd2: trk_q <= dec_byte;
                  3'd3: id2_q <= dec_byte;
                  3'd4: begin
                    hdr_valid_q  <= 1'b1;
                    hdr_track_q  <= trk_q;
                    hdr_sector_q <= sec_q;
                    hdr_id_q     <= {dec_byte, id2_q};
                    hdr_cks_ok_q <= hdr_ok;
                    hdr_seen_q   <= hdr_ok & sec_ok & trk_match;
                    gcr_err_q    <= ~trk_match;
                    state_q      <= StHunt;
                  end
                  default: ;
                endcase
              end
            end
          end
          StData: begin
            if (grp_rdy) begin
              if (!code_ok) begin
                gcr_err_q <= 1'b1;
                state_q   <= StHunt;
              end else if (cnt_q[8]) begin
                // 257th byte is the checksum; one header authorises one block.
                sector_done_q <= 1'b1;
                data_cks_ok_q <= (xor_q == dec_byte);
                hdr_seen_q    <= 1'b0;
                state_q       <= StHunt;
              end else begin
                buf_we_q   <= hdr_seen_q;
                buf_addr_q <= AddrWidth'({hdr_sector_q[4:0], cnt_q[7:0]});
                buf_data_q <= dec_byte;
                xor_q      <= xor_q ^ dec_byte;
                cnt_q      <= cnt_q + 9'd1;
              end
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign hdr_valid_o   = hdr_valid_q;
  assign hdr_track_o   = hdr_track_q;
  assign hdr_sector_o  = hdr_sector_q;
  assign hdr_id_o      = hdr_id_q;
  assign hdr_cks_ok_o  = hdr_cks_ok_q;
  assign buf_we_o      = buf_we_q;
  assign buf_addr_o    = buf_addr_q;
  assign buf_data_o    = buf_data_q;
  assign sector_done_o = sector_done_q;
  assign data_cks_ok_o = data_cks_ok_q;
  assign gcr_err_o     = gcr_err_q;

endmodule

// File: tb/tb_c1541_gcr_decoder.sv
// Directed bench for c1541_gcr_decoder: GCR-encodes header/data blocks and checks the decoded
// header fields, buffer writes and status pulses.
module tb_c1541_gcr_decoder;

  logic        clk = 1'b0;
  logic        rst_n, ce, bit_valid, bit_in;
  logic [5:0]  track;
  logic        sync_n, hdr_valid, hdr_cks_ok, buf_we, sector_done, data_cks_ok, gcr_err;
  logic [7:0]  hdr_track, hdr_sector, buf_data;
  logic [15:0] hdr_id;
  logic [12:0] buf_addr;

  int tests = 0;
  int failed = 0;
  bit gaps = 1'b0;
  logic [7:0] blk [256];

  always #5 clk = ~clk;

  c1541_gcr_decoder #(
    .SyncOnes (10),
    .AddrWidth(13)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ce_i         (ce),
    .bit_valid_i  (bit_valid),
    .bit_in_i     (bit_in),
    .track_i      (track),
    .sync_n_o     (sync_n),
    .hdr_valid_o  (hdr_valid),
    .hdr_track_o  (hdr_track),
    .hdr_sector_o (hdr_sector),
    .hdr_id_o     (hdr_id),
    .hdr_cks_ok_o (hdr_cks_ok),
    .buf_we_o     (buf_we),
    .buf_addr_o   (buf_addr),
    .buf_data_o   (buf_data),
    .sector_done_o(sector_done),
    .data_cks_ok_o(data_cks_ok),
    .gcr_err_o    (gcr_err)
  );

  // Event monitor, sampled on the falling edge.
  int n_we = 0, n_done = 0, n_hdr = 0, n_err = 0, n_sync_low = 0;
  logic [12:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  logic [7:0]  last_trk = 8'h00, last_sec = 8'h00;
  logic [15:0] last_id = 16'h0000;
  logic        last_hcks = 1'b0, last_dcks = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (buf_we) begin
        n_we++;
        wr_addr.push_back(buf_addr);
        wr_data.push_back(buf_data);
      end
      if (hdr_valid) begin
        n_hdr++;
        last_trk  = hdr_track;
        last_sec  = hdr_sector;
        last_id   = hdr_id;
        last_hcks = hdr_cks_ok;
      end
      if (sector_done) begin
        n_done++;
        last_dcks = data_cks_ok;
      end
      if (gcr_err) n_err++;
      if (!sync_n) n_sync_low++;
    end
  end

  function automatic logic [4:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 5'b01010;  4'h1: enc = 5'b01011;  4'h2: enc = 5'b10010;  4'h3: enc = 5'b10011;
      4'h4: enc = 5'b01110;  4'h5: enc = 5'b01111;  4'h6: enc = 5'b10110;  4'h7: enc = 5'b10111;
      4'h8: enc = 5'b01001;  4'h9: enc = 5'b11001;  4'hA: enc = 5'b11010;  4'hB: enc = 5'b11011;
      4'hC: enc = 5'b01101;  4'hD: enc = 5'b11101;  4'hE: enc = 5'b11110;  default: enc = 5'b10101;
    endcase
  endfunction

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_code10(input logic [9:0] c);
    for (int i = 9; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_code10({enc(b[7:4]), enc(b[3:0])});
  endtask

  task automatic send_ones(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_header(input logic [7:0] trk, input logic [7:0] sec,
                             input logic [7:0] id1, input logic [7:0] id2, input logic [7:0] cks);
    send_ones(12);
    send_byte(8'h08);
    send_byte(cks);
    send_byte(sec);
    send_byte(trk);
    send_byte(id2);
    send_byte(id1);
    send_byte(8'h0F);
    send_byte(8'h0F);
    idle(3);
  endtask

  task automatic send_data_block(input logic [7:0] cks);
    send_ones(12);
    send_byte(8'h07);
    for (int i = 0; i < 256; i++) send_byte(blk[i]);
    send_byte(cks);
    idle(4);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) blk[i] = 8'(i);
  endtask

  // Number of the 256 logged writes from 'start' that differ from blk at sector 'sec'.
  function automatic int count_bad(input int start, input logic [4:0] sec);
    int bad;
    bad = 0;
    if (wr_addr.size() < start + 256) return 256;
    for (int i = 0; i < 256; i++) begin
      if (wr_addr[start+i] !== {sec, 8'(i)} || wr_data[start+i] !== blk[i]) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; track = 6'd18;
    idle(3);
    tests++; if (sync_n !== 1'b1) begin failed++; $display("FAIL reset_sync_n got %b want 1", sync_n); end
    tests++; if (hdr_valid !== 1'b0) begin failed++; $display("FAIL reset_hdr_valid got %b want 0", hdr_valid); end
    tests++; if (buf_we !== 1'b0) begin failed++; $display("FAIL reset_buf_we got %b want 0", buf_we); end
    tests++; if (buf_addr !== 13'h0) begin failed++; $display("FAIL reset_buf_addr got %h want 0", buf_addr); end
    tests++; if (sector_done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", sector_done); end
    tests++; if (gcr_err !== 1'b0) begin failed++; $display("FAIL reset_gcr_err got %b want 0", gcr_err); end
    tests++; if (hdr_id !== 16'h0) begin failed++; $display("FAIL reset_hdr_id got %h want 0", hdr_id); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_header();
    int h0, e0;
    h0 = n_hdr; e0 = n_err;
    send_header(8'h12, 8'h03, 8'h41, 8'h42, 8'h12);
    tests++; if (n_hdr - h0 !== 1) begin failed++; $display("FAIL hdr_count got %0d want 1", n_hdr - h0); end
    tests++; if (last_trk !== 8'h12) begin failed++; $display("FAIL hdr_track got %h want 12", last_trk); end
    tests++; if (last_sec !== 8'h03) begin failed++; $display("FAIL hdr_sector got %h want 03", last_sec); end
    tests++; if (last_id !== 16'h4142) begin failed++; $display("FAIL hdr_id got %h want 4142", last_id); end
    tests++; if (last_hcks !== 1'b1) begin failed++; $display("FAIL hdr_cks_ok got %b want 1", last_hcks); end
    tests++; if (n_err - e0 !== 0) begin failed++; $display("FAIL hdr_err got %0d want 0", n_err - e0); end
  endtask

  task automatic test_data();
    int w0, d0, s0, bad;
    fill_ramp();
    w0 = n_we; d0 = n_done; s0 = wr_addr.size();
    send_data_block(8'h00);
    bad = count_bad(s0, 5'd3);
    tests++; if (n_we - w0 !== 256) begin failed++; $display("FAIL data_we got %0d want 256", n_we - w0); end
    tests++; if (bad !== 0) begin failed++; $display("FAIL data_addr_bytes got %0d bad want 0", bad); end
    tests++; if (n_done - d0 !== 1) begin failed++; $display("FAIL data_done got %0d want 1", n_done - d0); end
    tests++; if (last_dcks !== 1'b1) begin failed++; $display("FAIL data_cks_ok got %b want 1", last_dcks); end
  endtask

  task automatic test_corrupt();
    int w0, s0, bad;
    send_header(8'h12, 8'h03, 8'h41, 8'h42, 8'h12);
    fill_ramp();
    blk[5] = 8'h55;
    w0 = n_we; s0 = wr_addr.size();
    send_data_block(8'h00);
    bad = count_bad(s0, 5'd3);
    tests++; if (n_we - w0 !== 256) begin failed++; $display("FAIL corrupt_we got %0d want 256", n_we - w0); end
    tests++; if (bad !== 0) begin failed++; $display("FAIL corrupt_bytes got %0d bad want 0", bad); end
    tests++; if (last_dcks !== 1'b0) begin failed++; $display("FAIL corrupt_cks_ok got %b want 0", last_dcks); end
  endtask

  task automatic test_no_header();
    int w0, d0;
    send_header(8'h12, 8'h03, 8'h41, 8'h42, 8'h13);
    tests++; if (last_hcks !== 1'b0) begin failed++; $display("FAIL badhdr_cks_ok got %b want 0", last_hcks); end
    fill_ramp();
    w0 = n_we; d0 = n_done;
    send_data_block(8'h00);
    tests++; if (n_we - w0 !== 0) begin failed++; $display("FAIL badhdr_we got %0d want 0", n_we - w0); end
    tests++; if (n_done - d0 !== 1) begin failed++; $display("FAIL badhdr_done got %0d want 1", n_done - d0); end
    tests++; if (last_dcks !== 1'b1) begin failed++; $display("FAIL badhdr_cks_ok got %b want 1", last_dcks); end
  endtask

  task automatic test_gcr_err();
    int w0, d0, e0, q0;
    send_header(8'h12, 8'h03, 8'h41, 8'h42, 8'h12);
    fill_ramp();
    send_ones(12);
    send_byte(8'h07);
    w0 = n_we; d0 = n_done; e0 = n_err; q0 = n_sync_low;
    for (int i = 0; i < 40; i++) send_byte(blk[i]);
    send_code10(10'b11111_01010);
    for (int i = 41; i < 256; i++) send_byte(blk[i]);
    send_byte(8'h00);
    idle(4);
    tests++; if (n_err - e0 !== 1) begin failed++; $display("FAIL illegal_err got %0d want 1", n_err - e0); end
    tests++; if (n_done - d0 !== 0) begin failed++; $display("FAIL illegal_done got %0d want 0", n_done - d0); end
    tests++; if (n_we - w0 !== 40) begin failed++; $display("FAIL illegal_we got %0d want 40", n_we - w0); end
    tests++; if (n_sync_low - q0 !== 0) begin failed++; $display("FAIL illegal_sync got %0d want 0", n_sync_low - q0); end
  endtask

  task automatic test_sync_abort();
    int w0, d0, e0, s0, bad;
    send_header(8'h12, 8'h03, 8'h41, 8'h42, 8'h12);
    fill_ramp();
    send_ones(12);
    send_byte(8'h07);
    w0 = n_we; d0 = n_done; e0 = n_err;
    for (int i = 0; i < 40; i++) send_byte(blk[i]);
    send_code10(10'b11111_11111);
    tests++; if (sync_n !== 1'b0) begin failed++; $display("FAIL abort_sync_n got %b want 0", sync_n); end
    idle(3);
    tests++; if (n_err - e0 !== 0) begin failed++; $display("FAIL abort_err got %0d want 0", n_err - e0); end
    tests++; if (n_done - d0 !== 0) begin failed++; $display("FAIL abort_done got %0d want 0", n_done - d0); end
    tests++; if (n_we - w0 !== 40) begin failed++; $display("FAIL abort_we got %0d want 40", n_we - w0); end
    send_header(8'h12, 8'h03, 8'h41, 8'h42, 8'h12);
    s0 = wr_addr.size(); d0 = n_done;
    send_data_block(8'h00);
    bad = count_bad(s0, 5'd3);
    tests++; if (bad !== 0) begin failed++; $display("FAIL abort_next_bytes got %0d bad want 0", bad); end
    tests++; if (n_done - d0 !== 1) begin failed++; $display("FAIL abort_next_done got %0d want 1", n_done - d0); end
    tests++; if (last_dcks !== 1'b1) begin failed++; $display("FAIL abort_next_cks got %b want 1", last_dcks); end
  endtask

  task automatic test_sector_limit();
    int w0, d0, s0, bad;
    gaps = 1'b1;
    fill_ramp();
    blk[0] = 8'hA5;
    send_header(8'h12, 8'd20, 8'h41, 8'h42, 8'h05);
    w0 = n_we; s0 = wr_addr.size();
    send_data_block(8'hA5);
    bad = count_bad(s0, 5'd20);
    tests++; if (n_we - w0 !== 256) begin failed++; $display("FAIL sec20_we got %0d want 256", n_we - w0); end
    tests++; if (bad !== 0) begin failed++; $display("FAIL sec20_bytes got %0d bad want 0", bad); end
    tests++; if (last_dcks !== 1'b1) begin failed++; $display("FAIL sec20_cks_ok got %b want 1", last_dcks); end
    send_header(8'h12, 8'd21, 8'h41, 8'h42, 8'h04);
    tests++; if (last_hcks !== 1'b1) begin failed++; $display("FAIL sec21_hcks got %b want 1", last_hcks); end
    w0 = n_we; d0 = n_done;
    send_data_block(8'hA5);
    tests++; if (n_we - w0 !== 0) begin failed++; $display("FAIL sec21_we got %0d want 0", n_we - w0); end
    tests++; if (n_done - d0 !== 1) begin failed++; $display("FAIL sec21_done got %0d want 1", n_done - d0); end
    gaps = 1'b0;
  endtask

`ifdef C1541_GCR_DEC_TRACK_CHECK_EN
  task automatic test_track_check();
    int h0, e0, w0;
    track = 6'd17;
    h0 = n_hdr; e0 = n_err;
    send_header(8'h12, 8'h03, 8'h41, 8'h42, 8'h12);
    tests++; if (n_hdr - h0 !== 1) begin failed++; $display("FAIL trk_hdr got %0d want 1", n_hdr - h0); end
    tests++; if (n_err - e0 !== 1) begin failed++; $display("FAIL trk_err got %0d want 1", n_err - e0); end
    fill_ramp();
    w0 = n_we;
    send_data_block(8'h00);
    tests++; if (n_we - w0 !== 0) begin failed++; $display("FAIL trk_we got %0d want 0", n_we - w0); end
    track = 6'd18;
  endtask
`endif

  task automatic test_async_reset();
    int w0, d0;
    send_header(8'h12, 8'h03, 8'h41, 8'h42, 8'h12);
    fill_ramp();
    send_ones(12);
    send_byte(8'h07);
    for (int i = 0; i < 100; i++) send_byte(blk[i]);
    #3 rst_n = 1'b0;
    #1;
    tests++; if (hdr_sector !== 8'h00) begin failed++; $display("FAIL arst_hdr_sector got %h want 00", hdr_sector); end
    tests++; if (buf_addr !== 13'h0) begin failed++; $display("FAIL arst_buf_addr got %h want 0", buf_addr); end
    tests++; if (buf_data !== 8'h00) begin failed++; $display("FAIL arst_buf_data got %h want 00", buf_data); end
    #2 rst_n = 1'b1;
    idle(2);
    w0 = n_we; d0 = n_done;
    send_data_block(8'h00);
    tests++; if (n_we - w0 !== 0) begin failed++; $display("FAIL arst_we got %0d want 0", n_we - w0); end
    tests++; if (n_done - d0 !== 1) begin failed++; $display("FAIL arst_done got %0d want 1", n_done - d0); end
  endtask

  initial begin
    test_reset();
    test_header();
    test_data();
    test_corrupt();
    test_no_header();
    test_gcr_err();
    test_sync_abort();
    test_sector_limit();
`ifdef C1541_GCR_DEC_TRACK_CHECK_EN
    test_track_check();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/c1541_gcr_decoder.md
Name: c1541_gcr_decoder

Overview:
- Reader-side counterpart of the 1541 GCR track generator.
- Consumes a serial raw GCR bitstream (G64 track playback or the 1541 write head path), detects SYNC and frames 10-bit GCR groups into bytes.
- Parses header (mark 0x08) and data (mark 0x07) blocks and checks both checksums.
- Writes decoded sector bytes into the D64-style sector buffer at address {sector, byte}.

Parameters:
- SYNC_ONES, 10: consecutive 1 bits that constitute SYNC.
- ADDR_WIDTH, 13: buffer address width, {sector[4:0], byte[7:0]}.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all state advances only when ce=1
- bit_valid  in  1  qualifies bit_in for this ce cycle
- bit_in  in  1  next GCR bit, MSB-first
- track  in  6  current head track (used by optional feature)
- sync_n  out  1  0 while inside SYNC
- hdr_valid  out  1  one-ce pulse when a header has been decoded
- hdr_track  out  8  header track field
- hdr_sector  out  8  header sector field
- hdr_id  out  16  {id1, id2}
- hdr_cks_ok  out  1  header checksum matched (qualified by hdr_valid)
- buf_we  out  1  buffer write strobe, one ce-cycle
- buf_addr  out  ADDR_WIDTH  {sector, byte index}
- buf_data  out  8  decoded data byte
- sector_done  out  1  one-ce pulse after the 256th data byte and the checksum
- data_cks_ok  out  1  data checksum matched (qualified by sector_done)
- gcr_err  out  1  one-ce pulse on an illegal 5-bit code

Behaviour:
- Reset values: every output is 0, except sync_n=1. FSM resets to HUNT and hdr_seen=0.
- Ones counter:
  - Increments on each valid 1 bit and clears on a 0 bit.
  - Saturates at SYNC_ONES; reaching it asserts sync_n=0 and forces the SYNC state from any state, aborting any block in progress with no pulses.
- SYNC -> MARK on the first 0 bit. That 0 is bit 9 of the first 10-bit group, and bit counter=1 after it.
- Framing: 10 valid bits form one group. The upper 5 bits decode to the high nibble, the lower 5 bits to the low nibble.
  - Illegal codes are 00000, 00001, 00010, 00011, 00100, 00101, 00110, 00111, 01000, 01100, 10000, 10001, 10100, 11000, 11100, 11111.
  - An illegal code pulses gcr_err and goes to HUNT.
- Byte-ready timing: a byte is ready in the ce-cycle after its 10th bit, giving 1 ce latency.
- MARK state:
  - byte 0x08 -> HEADER.
  - byte 0x07 -> DATA.
  - any other byte -> HUNT.
- HEADER state:
  - Receives 5 bytes in order: cks, sector, track, id2, id1.
  - After id1, latch the fields and pulse hdr_valid.
  - hdr_cks_ok = (cks == sector ^ track ^ id1 ^ id2).
  - hdr_seen is set only when the checksum is OK and sector <= 20; otherwise it is cleared.
  - Then -> HUNT; the trailing 0x0F padding is ignored.
- DATA state:
  - Byte index runs 0..255.
  - Each byte: buf_we=1, buf_addr={hdr_sector[4:0], index}, buf_data=byte. Writes are suppressed while hdr_seen=0, but decoding still proceeds.
  - Running XOR of the 256 bytes; the 257th byte is the checksum. Pulse sector_done with data_cks_ok = (xor == cks).
  - hdr_seen is cleared after sector_done, so one header authorises one data block. Then -> HUNT.
  - Index wraps only via the state exit; it never overflows into the sector bits.
- HUNT: discard bits until SYNC.
- bit_valid=0 or ce=0 holds all state; pulse outputs are 1 ce-cycle wide.
- Simultaneous events: SYNC detection on the same bit as completion of a group takes precedence; the group is dropped.
- Async reset mid-block: outputs drop to reset values immediately and no partial pulse is emitted.

Optional Feature:
- Macro: C1541_GCR_DEC_TRACK_CHECK_EN.
- When defined: a header whose hdr_track != {2'b00, track} still pulses hdr_valid, but does not set hdr_seen and pulses gcr_err. This prevents buffer writes after a mis-step.
- When undefined: the track port is ignored.

Decomposition:
- Package c1541_gcr_pkg holds:
  - gcr_decode function (5-bit to {valid, nibble}) and gcr_encode LUT
  - MARK_HEADER = 8'h08, MARK_DATA = 8'h07
  - state enum (HUNT, SYNC, MARK, HEADER, DATA)
  - SECTORS_MAX = 20
- Sub-module c1541_gcr_deframer: ones counter, sync_n, 10-bit shift and byte-ready. The FSM and checksums stay in the top module.

Test Plan:
- 12 ones, 0x08 header for track 18, sector 3, id "AB", cks 0x12 -> hdr_valid with hdr_track=0x12, hdr_sector=0x03, hdr_id=0x4142, hdr_cks_ok=1.
- That header, then SYNC, 0x07, bytes 0x00..0xFF, cks 0x00 -> 256 buf_we at addresses 0x0300..0x03FF, then sector_done with data_cks_ok=1.
- Same stream with data byte 5 corrupted to 0x55 -> writes still occur, data_cks_ok=0.
- Data block without a preceding valid header (header cks wrong) -> hdr_cks_ok=0, zero buf_we, sector_done still pulses.
- Group 11111 inside a data block at byte 40 -> gcr_err pulse only if fewer than 10 ones; 10 ones -> sync_n=0, no sector_done, next block decodes correctly.
- With C1541_GCR_DEC_TRACK_CHECK_EN and track=17, header track 18 -> hdr_valid=1, gcr_err=1, following data block produces no buf_we.
